// File: rtl/i2c_read_arbiter.sv
// Round-robin arbiter sharing one 2-byte I2C read engine between NREQ requesters,
// with start-pulse sequencing, per-transaction timeout and error reporting.
module i2c_read_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 200000,
    parameter int CNT_W       = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*7-1:0]   req_addr_i,
    output logic [NREQ-1:0]     done_o,
    output logic [15:0]         rsp_data_o,
    output logic                rsp_err_o,
    output logic                busy_o,
    output logic                eng_start_o,
    output logic [6:0]          eng_addr_o,
    input  logic                eng_busy_i,
    input  logic                eng_done_i,
    input  logic                eng_nack_i,
    input  logic [15:0]         eng_data_i
);

    localparam int IDX_W = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   winner_reg, winner_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [6:0]         addr_reg, addr_next;
    logic [15:0]        data_reg, data_next;
    logic               err_reg, err_next;

    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic [6:0]         addr_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_slice[gi] = req_addr_i[7*gi +: 7];
            assign done_o[gi]     = (state_reg == S_RESP) && (winner_reg == IDX_W'(gi));
        end
    endgenerate

    // Scan from the highest offset down so the nearest request at/after ptr wins.
    always_comb begin
        int j;
        grant_found = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_reg) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_i[j]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        winner_next = winner_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        data_next   = data_reg;
        err_next    = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_found && !eng_busy_i) begin
                    winner_next = grant_idx;
                    addr_next   = addr_slice[grant_idx];
                    state_next  = S_START;
                end
            end
            S_START: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                // A completing engine beats a coinciding timeout.
                if (eng_done_i) begin
                    data_next  = eng_data_i;
                    err_next   = eng_nack_i;
                    state_next = S_RESP;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                    data_next  = 16'h0000;
                    err_next   = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                ptr_next   = (winner_reg == IDX_W'(NREQ - 1)) ? '0 : winner_reg + IDX_W'(1);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            ptr_reg    <= '0;
            winner_reg <= '0;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            winner_reg <= winner_next;
            cnt_reg    <= cnt_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
            err_reg    <= err_next;
        end
    end

    assign busy_o      = (state_reg != S_IDLE);
    assign eng_start_o = (state_reg == S_START);
    assign eng_addr_o  = addr_reg;
    assign rsp_data_o  = data_reg;
    assign rsp_err_o   = err_reg;

endmodule
